// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    // Widest write-port count the block supports; hit vectors are sized to it.
    localparam int RF_MAX_WR = 2;

    typedef struct packed {
        logic vld;  // at least one write port matched
        logic idx;  // index of the winning (highest) matching port
    } wr_sel_t;

    // Picks the highest-index write port whose hit bit is set.
    function automatic wr_sel_t rf_sel_wr(input logic [RF_MAX_WR-1:0] hit);
        wr_sel_t sel;
        sel.vld = |hit;
        sel.idx = hit[1];
        return sel;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register write-pending (busy) bits; set on issue, cleared on writeback.
// Latency: set/clear take effect at the next rising edge; output is registered.
// Backpressure: none; set beats clear on the same register in the same cycle.
// Ports: i_clr_vec one bit per register to clear, i_set/i_set_addr issue marking,
//        o_busy_vec registered busy bits with bit 0 held at 0.
module rf_scoreboard #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DEPTH-1:0] i_clr_vec,
    input  logic             i_set,
    input  logic [AW-1:0]    i_set_addr,
    output logic [DEPTH-1:0] o_busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q & ~i_clr_vec;
        // Applied after the clear so a new producer (WAW) keeps the bit set.
        if (i_set && (i_set_addr != '0)) begin
            busy_d[i_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy_vec = busy_q;

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port register file (x0 hardwired to zero) with integrated busy scoreboard.
// Latency: reads combinational (optional same-cycle write bypass); writes/busy at next edge.
// Backpressure: none; issue logic must check o_rs_busy before asserting i_sb_set.
// Ports: i_rs_raddr/o_rs_rdata/o_rs_busy per read port k at [k*AW]/[k*XLEN]/[k];
//        i_rd_wen/i_rd_waddr/i_rd_wdata per write port (higher index wins);
//        i_sb_set/i_sb_addr mark a destination busy; o_busy_vec raw busy bits.
module rf_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_RD*AW-1:0]   i_rs_raddr,
    output logic [NUM_RD*XLEN-1:0] o_rs_rdata,
    output logic [NUM_RD-1:0]      o_rs_busy,
    input  logic [NUM_WR-1:0]      i_rd_wen,
    input  logic [NUM_WR*AW-1:0]   i_rd_waddr,
    input  logic [NUM_WR*XLEN-1:0] i_rd_wdata,
    input  logic                   i_sb_set,
    input  logic [AW-1:0]          i_sb_addr,
    output logic [DEPTH-1:0]       o_busy_vec
);

    logic [XLEN-1:0]      mem_q [DEPTH];
    logic [XLEN-1:0]      mem_d [DEPTH];
    logic [DEPTH-1:0]     clr_vec;
    logic [AW-1:0]        raddr;
    logic [RF_MAX_WR-1:0] hit;
    wr_sel_t              sel;

    // Ascending port order makes the highest-index port's data the one stored.
    always_comb begin
        mem_d   = mem_q;
        clr_vec = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (i_rd_wen[j] && (i_rd_waddr[j*AW +: AW] != '0)) begin
                mem_d[i_rd_waddr[j*AW +: AW]]   = i_rd_wdata[j*XLEN +: XLEN];
                clr_vec[i_rd_waddr[j*AW +: AW]] = 1'b1;
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr_vec  (clr_vec),
        .i_set      (i_sb_set),
        .i_set_addr (i_sb_addr),
        .o_busy_vec (o_busy_vec)
    );

    // Read muxes. Bypass is gated by reset so every port reads 0 while in reset.
    always_comb begin
        o_rs_rdata = '0;
        o_rs_busy  = '0;
        raddr      = '0;
        hit        = '0;
        sel        = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            raddr = i_rs_raddr[k*AW +: AW];
            hit   = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                hit[j] = (BYPASS_EN != 0) && i_rst_n && i_rd_wen[j]
                         && (i_rd_waddr[j*AW +: AW] == raddr);
            end
            sel = rf_sel_wr(hit);
            if (raddr == '0) begin
                o_rs_rdata[k*XLEN +: XLEN] = '0;
                o_rs_busy[k]               = 1'b0;
            end else if (sel.vld) begin
                o_rs_rdata[k*XLEN +: XLEN] = i_rd_wdata[int'(sel.idx)*XLEN +: XLEN];
                o_rs_busy[k]               = 1'b0;
            end else begin
                o_rs_rdata[k*XLEN +: XLEN] = mem_q[raddr];
                o_rs_busy[k]               = o_busy_vec[raddr];
            end
        end
    end

endmodule
